ro_buffer: RTL and testbench

- Reorder buffer for the Tomasulo core. Allocates in-order tags (ROB ids) to the issuer and captures results from the CDB.
- Commits one entry per cycle, in order, to the register file's ro-buffer port (dest/rd/value).
- Drives the flush pulse (rob bus reset) on branch mispredict.
- Tag 0 means "no producer", so valid ids are 1..DEPTH.

---
 rtl/ro_buffer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ro_buffer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_buffer.sv
// -----------------------------------------------------------------------------
// ro_buffer
//   Reorder buffer for the Tomasulo core. Hands out in-order ROB ids
//   (1..DEPTH, 0 = "no producer") to the issuer. Captures results broadcast
//   on the CDB. Commits one ready entry per cycle, in order, to the register
//   file. On a branch mispredict it raises a one-cycle flush pulse together
//   with the redirect PC.
//
// Parameters
//   ID_W  ROB id width; DEPTH = 2**ID_W - 1 entries
//   XLEN  data / PC width
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   rdy                             global enable; low freezes all state
//   issue_*/rd/is_branch/pred_taken/alt_pc _from_issuer
//                                   issue request and entry fields
//   issue_ready_to_issuer           an entry can be accepted this cycle
//   dest_to_issuer                  tag assigned this cycle (current tail)
//   qj/qk_from_issuer               operand tags to look up
//   ready/value_j/k_to_issuer       lookup results (combinational)
//   cdb_valid/dest/value/taken      result broadcast
//   dest/rd/value_to_reg_file       registered commit, valid for one cycle
//   reset_to_rob_bus                one-cycle flush pulse
//   pc_to_fetcher                   redirect target, valid with the flush
//
// Optional build macro
//   ROB_BYPASS_EN  operand lookup also hits on a same-cycle CDB broadcast
// -----------------------------------------------------------------------------
module ro_buffer #(
   parameter int ID_W = 4,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rdy,

   input  logic            issue_valid_from_issuer,
   output logic            issue_ready_to_issuer,
   input  logic [4:0]      rd_from_issuer,
   input  logic            is_branch_from_issuer,
   input  logic            pred_taken_from_issuer,
   input  logic [XLEN-1:0] alt_pc_from_issuer,
   output logic [ID_W-1:0] dest_to_issuer,

   input  logic [ID_W-1:0] qj_from_issuer,
   input  logic [ID_W-1:0] qk_from_issuer,
   output logic            ready_j_to_issuer,
   output logic            ready_k_to_issuer,
   output logic [XLEN-1:0] value_j_to_issuer,
   output logic [XLEN-1:0] value_k_to_issuer,

   input  logic            cdb_valid,
   input  logic [ID_W-1:0] cdb_dest,
   input  logic [XLEN-1:0] cdb_value,
   input  logic            cdb_taken,

   output logic [ID_W-1:0] dest_to_reg_file,
   output logic [4:0]      rd_to_reg_file,
   output logic [XLEN-1:0] value_to_reg_file,

   output logic            reset_to_rob_bus,
   output logic [XLEN-1:0] pc_to_fetcher
);

   // Entry 0 exists only so every ID_W-bit tag indexes the arrays directly;
   // it is never issued, so it never becomes busy.
   localparam int NENT = 2 ** ID_W;
   localparam logic [ID_W-1:0] LAST_ID  = '1;
   localparam logic [ID_W-1:0] FIRST_ID = ID_W'(1);

   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      return (id == LAST_ID) ? FIRST_ID : id + FIRST_ID;
   endfunction

   // ---------------------------------------------------------------- state
   logic            busy_q       [NENT];
   logic            busy_d       [NENT];
   logic            ready_q      [NENT];
   logic            ready_d      [NENT];
   logic [4:0]      rd_q         [NENT];
   logic [4:0]      rd_d         [NENT];
   logic [XLEN-1:0] value_q      [NENT];
   logic [XLEN-1:0] value_d      [NENT];
   logic            is_branch_q  [NENT];
   logic            is_branch_d  [NENT];
   logic            pred_taken_q [NENT];
   logic            pred_taken_d [NENT];
   logic            taken_q      [NENT];
   logic            taken_d      [NENT];
   logic [XLEN-1:0] alt_pc_q     [NENT];
   logic [XLEN-1:0] alt_pc_d     [NENT];

   logic [ID_W-1:0] head_q, head_d;
   logic [ID_W-1:0] tail_q, tail_d;
   logic [ID_W-1:0] count_q, count_d;

   logic [ID_W-1:0] rf_dest_q, rf_dest_d;
   logic [4:0]      rf_rd_q, rf_rd_d;
   logic [XLEN-1:0] rf_value_q, rf_value_d;
   logic            flush_q, flush_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   // ------------------------------------------------------ control decode
   logic issue_fire;
   logic cdb_take;
   logic commit_en;
   logic mispredict;

   // count == LAST_ID is the full condition since DEPTH = 2**ID_W - 1.
   assign issue_ready_to_issuer = rst_n && rdy && !flush_q && (count_q != LAST_ID);
   assign dest_to_issuer        = tail_q;

   assign issue_fire = issue_valid_from_issuer && issue_ready_to_issuer;
   assign cdb_take   = rdy && !flush_q && cdb_valid && (cdb_dest != '0) && busy_q[cdb_dest];
   assign commit_en  = rdy && busy_q[head_q] && ready_q[head_q];
   assign mispredict = commit_en && is_branch_q[head_q]
                       && (taken_q[head_q] != pred_taken_q[head_q]);

   // --------------------------------------------------------- next state
   // Ordering: CDB capture, then issue, then commit clear, then flush.
   // Commit clears after the CDB write so a late broadcast to the head being
   // retired cannot resurrect it; the flush overrides everything, which also
   // drops an issue accepted on the mispredicting edge.
   always_comb begin
      busy_d       = busy_q;
      ready_d      = ready_q;
      rd_d         = rd_q;
      value_d      = value_q;
      is_branch_d  = is_branch_q;
      pred_taken_d = pred_taken_q;
      taken_d      = taken_q;
      alt_pc_d     = alt_pc_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;

      rf_dest_d     = '0;
      rf_rd_d       = '0;
      rf_value_d    = '0;
      flush_d       = 1'b0;
      redirect_pc_d = '0;

      if (cdb_take) begin
         ready_d[cdb_dest] = 1'b1;
         value_d[cdb_dest] = cdb_value;
         taken_d[cdb_dest] = cdb_taken;
      end

      if (issue_fire) begin
         busy_d[tail_q]       = 1'b1;
         ready_d[tail_q]      = 1'b0;
         rd_d[tail_q]         = rd_from_issuer;
         value_d[tail_q]      = '0;
         is_branch_d[tail_q]  = is_branch_from_issuer;
         pred_taken_d[tail_q] = pred_taken_from_issuer;
         taken_d[tail_q]      = 1'b0;
         alt_pc_d[tail_q]     = alt_pc_from_issuer;
         tail_d               = next_id(tail_q);
      end

      if (commit_en) begin
         rf_dest_d       = head_q;
         rf_rd_d         = rd_q[head_q];
         rf_value_d      = value_q[head_q];
         busy_d[head_q]  = 1'b0;
         ready_d[head_q] = 1'b0;
         value_d[head_q] = '0;
         head_d          = next_id(head_q);
      end

      case ({issue_fire, commit_en})
         2'b10:   count_d = count_q + FIRST_ID;
         2'b01:   count_d = count_q - FIRST_ID;
         default: count_d = count_q;
      endcase

      if (mispredict) begin
         flush_d       = 1'b1;
         redirect_pc_d = alt_pc_q[head_q];
         for (int unsigned i = 0; i < NENT; i++) begin
            busy_d[i]  = 1'b0;
            ready_d[i] = 1'b0;
            value_d[i] = '0;
         end
         head_d  = FIRST_ID;
         tail_d  = FIRST_ID;
         count_d = '0;
      end
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q        <= '{default: '0};
         ready_q       <= '{default: '0};
         rd_q          <= '{default: '0};
         value_q       <= '{default: '0};
         is_branch_q   <= '{default: '0};
         pred_taken_q  <= '{default: '0};
         taken_q       <= '{default: '0};
         alt_pc_q      <= '{default: '0};
         head_q        <= FIRST_ID;
         tail_q        <= FIRST_ID;
         count_q       <= '0;
         rf_dest_q     <= '0;
         rf_rd_q       <= '0;
         rf_value_q    <= '0;
         flush_q       <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         busy_q        <= busy_d;
         ready_q       <= ready_d;
         rd_q          <= rd_d;
         value_q       <= value_d;
         is_branch_q   <= is_branch_d;
         pred_taken_q  <= pred_taken_d;
         taken_q       <= taken_d;
         alt_pc_q      <= alt_pc_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         rf_dest_q     <= rf_dest_d;
         rf_rd_q       <= rf_rd_d;
         rf_value_q    <= rf_value_d;
         flush_q       <= flush_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign dest_to_reg_file  = rf_dest_q;
   assign rd_to_reg_file    = rf_rd_q;
   assign value_to_reg_file = rf_value_q;
   assign reset_to_rob_bus  = flush_q;
   assign pc_to_fetcher     = redirect_pc_q;

   // -------------------------------------------------------- operand lookup
   always_comb begin
      ready_j_to_issuer = 1'b0;
      value_j_to_issuer = '0;
      ready_k_to_issuer = 1'b0;
      value_k_to_issuer = '0;

      if (qj_from_issuer != '0) begin
         ready_j_to_issuer = busy_q[qj_from_issuer] && ready_q[qj_from_issuer];
         value_j_to_issuer = value_q[qj_from_issuer];
      end
      if (qk_from_issuer != '0) begin
         ready_k_to_issuer = busy_q[qk_from_issuer] && ready_q[qk_from_issuer];
         value_k_to_issuer = value_q[qk_from_issuer];
      end

`ifdef ROB_BYPASS_EN
      // A same-cycle broadcast wins over whatever is stored for that tag.
      if (cdb_valid && (qj_from_issuer != '0) && (cdb_dest == qj_from_issuer)) begin
         ready_j_to_issuer = 1'b1;
         value_j_to_issuer = cdb_value;
      end
      if (cdb_valid && (qk_from_issuer != '0) && (cdb_dest == qk_from_issuer)) begin
         ready_k_to_issuer = 1'b1;
         value_k_to_issuer = cdb_value;
      end
`else
      // Stored state only: a result is visible the cycle after its broadcast.
`endif
   end

endmodule

// File: tb/tb_ro_buffer.sv
// -----------------------------------------------------------------------------
// tb_ro_buffer
//   Directed-vector bench for ro_buffer (ID_W=4, XLEN=32). Inputs change one
//   time unit after each rising edge; outputs are checked before the next edge.
//   Honors ROB_BYPASS_EN for the same-cycle lookup case.
// -----------------------------------------------------------------------------
module tb_ro_buffer;

   localparam int ID_W = 4;
   localparam int XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic            rdy;
   logic            issue_valid;
   logic            issue_ready;
   logic [4:0]      rd_in;
   logic            is_branch;
   logic            pred_taken;
   logic [XLEN-1:0] alt_pc;
   logic [ID_W-1:0] dest_iss;
   logic [ID_W-1:0] qj, qk;
   logic            ready_j, ready_k;
   logic [XLEN-1:0] value_j, value_k;
   logic            cdb_valid;
   logic [ID_W-1:0] cdb_dest;
   logic [XLEN-1:0] cdb_value;
   logic            cdb_taken;
   logic [ID_W-1:0] dest_rf;
   logic [4:0]      rd_rf;
   logic [XLEN-1:0] value_rf;
   logic            flush;
   logic [XLEN-1:0] pc_fetch;

   int n_checks = 0;
   int n_pass   = 0;

   ro_buffer #(.ID_W(ID_W), .XLEN(XLEN)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .rdy                     (rdy),
      .issue_valid_from_issuer (issue_valid),
      .issue_ready_to_issuer   (issue_ready),
      .rd_from_issuer          (rd_in),
      .is_branch_from_issuer   (is_branch),
      .pred_taken_from_issuer  (pred_taken),
      .alt_pc_from_issuer      (alt_pc),
      .dest_to_issuer          (dest_iss),
      .qj_from_issuer          (qj),
      .qk_from_issuer          (qk),
      .ready_j_to_issuer       (ready_j),
      .ready_k_to_issuer       (ready_k),
      .value_j_to_issuer       (value_j),
      .value_k_to_issuer       (value_k),
      .cdb_valid               (cdb_valid),
      .cdb_dest                (cdb_dest),
      .cdb_value               (cdb_value),
      .cdb_taken               (cdb_taken),
      .dest_to_reg_file        (dest_rf),
      .rd_to_reg_file          (rd_rf),
      .value_to_reg_file       (value_rf),
      .reset_to_rob_bus        (flush),
      .pc_to_fetcher           (pc_fetch)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0;
      rd_in       = '0;
      is_branch   = 1'b0;
      pred_taken  = 1'b0;
      alt_pc      = '0;
      qj          = '0;
      qk          = '0;
      cdb_valid   = 1'b0;
      cdb_dest    = '0;
      cdb_value   = '0;
      cdb_taken   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rdy = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic set_issue(input logic [4:0] rd);
      issue_valid = 1'b1;
      rd_in       = rd;
      is_branch   = 1'b0;
      pred_taken  = 1'b0;
      alt_pc      = '0;
   endtask

   task automatic set_cdb(input logic [ID_W-1:0] d, input logic [XLEN-1:0] v, input logic t);
      cdb_valid = 1'b1;
      cdb_dest  = d;
      cdb_value = v;
      cdb_taken = t;
   endtask

   initial begin
      rst_n = 1'b0;
      rdy   = 1'b1;
      idle_inputs();
      #2;
      // ---------------- reset state
      chk("rst_dest_rf",     64'(dest_rf),     64'd0);
      chk("rst_flush",       64'(flush),       64'd0);
      chk("rst_pc",          64'(pc_fetch),    64'd0);
      chk("rst_issue_ready", 64'(issue_ready), 64'd0);
      #4;
      rst_n = 1'b1;
      #1;
      chk("rel_issue_ready", 64'(issue_ready), 64'd1);
      chk("rel_dest_iss",    64'(dest_iss),    64'd1);

      // ---------------- in-order commit
      tick();
      set_issue(5'd5); #1; chk("t1_dest1", 64'(dest_iss), 64'd1); tick();
      set_issue(5'd6); #1; chk("t1_dest2", 64'(dest_iss), 64'd2); tick();
      set_issue(5'd7); #1; chk("t1_dest3", 64'(dest_iss), 64'd3); tick();
      issue_valid = 1'b0;
      set_cdb(4'd2, 32'hAA, 1'b0); tick();
      cdb_valid = 1'b0;
      chk("t1_idle_a", 64'(dest_rf), 64'd0);
      tick();
      chk("t1_idle_b", 64'(dest_rf), 64'd0);
      set_cdb(4'd1, 32'h11, 1'b0); tick();
      cdb_valid = 1'b0;
      chk("t1_no_same_edge", 64'(dest_rf), 64'd0);
      tick();
      chk("t1_c1_dest",  64'(dest_rf),  64'd1);
      chk("t1_c1_rd",    64'(rd_rf),    64'd5);
      chk("t1_c1_value", 64'(value_rf), 64'h11);
      tick();
      chk("t1_c2_dest",  64'(dest_rf),  64'd2);
      chk("t1_c2_rd",    64'(rd_rf),    64'd6);
      chk("t1_c2_value", 64'(value_rf), 64'hAA);
      tick();
      chk("t1_c3_idle",  64'(dest_rf),  64'd0);

      // ---------------- full buffer and tail wrap
      do_reset();
      for (int i = 0; i < 15; i++) begin
         set_issue(5'(i + 1));
         #1;
         chk($sformatf("t2_dest%0d", i + 1), 64'(dest_iss), 64'(i + 1));
         tick();
      end
      set_issue(5'd20);
      #1;
      chk("t2_full_refuse", 64'(issue_ready), 64'd0);
      chk("t2_tail_wrap",   64'(dest_iss),    64'd1);
      tick();
      issue_valid = 1'b0;
      set_cdb(4'd1, 32'h77, 1'b0); tick();
      cdb_valid = 1'b0;
      chk("t2_full_while_commit", 64'(issue_ready), 64'd0);
      tick();
      chk("t2_commit_dest",  64'(dest_rf),     64'd1);
      chk("t2_commit_value", 64'(value_rf),    64'h77);
      chk("t2_slot_free",    64'(issue_ready), 64'd1);
      set_issue(5'd9);
      #1;
      chk("t2_reuse_dest1", 64'(dest_iss), 64'd1);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("t2_full_again", 64'(issue_ready), 64'd0);

      // ---------------- mispredict flush
      do_reset();
      issue_valid = 1'b1; rd_in = 5'd0; is_branch = 1'b1; pred_taken = 1'b0;
      alt_pc = 32'h1000;
      #1; chk("t3_br_dest", 64'(dest_iss), 64'd1);
      tick();
      set_issue(5'd8); #1; chk("t3_young_dest", 64'(dest_iss), 64'd2); tick();
      issue_valid = 1'b0;
      set_cdb(4'd2, 32'h22, 1'b0); tick();
      set_cdb(4'd1, 32'h0, 1'b1); tick();
      cdb_valid = 1'b0;
      chk("t3_no_early_flush", 64'(flush), 64'd0);
      set_issue(5'd3);        // accepted on the mispredict edge, then dropped
      #1; chk("t3_late_issue_dest", 64'(dest_iss), 64'd3);
      tick();
      issue_valid = 1'b0;
      chk("t3_flush",         64'(flush),       64'd1);
      chk("t3_pc",            64'(pc_fetch),    64'h1000);
      chk("t3_br_commit",     64'(dest_rf),     64'd1);
      chk("t3_br_rd",         64'(rd_rf),       64'd0);
      chk("t3_dest_reset",    64'(dest_iss),    64'd1);
      chk("t3_ready_blocked", 64'(issue_ready), 64'd0);
      tick();
      chk("t3_flush_pulse",   64'(flush),       64'd0);
      chk("t3_pc_clear",      64'(pc_fetch),    64'd0);
      chk("t3_no_young",      64'(dest_rf),     64'd0);
      chk("t3_dest_after",    64'(dest_iss),    64'd1);
      tick();
      chk("t3_no_young_b",    64'(dest_rf),     64'd0);

      // ---------------- operand lookup
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         set_issue(5'(i));
         tick();
      end
      issue_valid = 1'b0;
      set_cdb(4'd3, 32'h55, 1'b0); tick();
      cdb_valid = 1'b0;
      qj = 4'd3; qk = 4'd0;
      #1;
      chk("t4_ready_j",   64'(ready_j), 64'd1);
      chk("t4_value_j",   64'(value_j), 64'h55);
      chk("t4_ready_k0",  64'(ready_k), 64'd0);
      chk("t4_value_k0",  64'(value_k), 64'd0);
      qk = 4'd2;
      #1;
      chk("t4_notready_k", 64'(ready_k), 64'd0);
      qj = 4'd4;
      set_cdb(4'd4, 32'h99, 1'b0);
      #1;
`ifdef ROB_BYPASS_EN
      chk("t4_bypass_ready", 64'(ready_j), 64'd1);
      chk("t4_bypass_value", 64'(value_j), 64'h99);
`else
      chk("t4_no_bypass", 64'(ready_j), 64'd0);
`endif
      tick();
      cdb_valid = 1'b0;
      #1;
      chk("t4_stored_ready", 64'(ready_j), 64'd1);
      chk("t4_stored_value", 64'(value_j), 64'h99);
      qj = '0; qk = '0;

      // ---------------- asynchronous reset mid-stream
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         set_issue(5'(i + 10));
         tick();
      end
      issue_valid = 1'b0;
      set_cdb(4'd1, 32'h33, 1'b0); tick();
      cdb_valid = 1'b0;
      tick();
      chk("t5_pre_commit", 64'(dest_rf), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_dest",  64'(dest_rf),     64'd0);
      chk("t5_async_rd",    64'(rd_rf),       64'd0);
      chk("t5_async_value", 64'(value_rf),    64'd0);
      chk("t5_async_ready", 64'(issue_ready), 64'd0);
      #1;
      rst_n = 1'b1;
      tick();
      chk("t5_no_stale", 64'(dest_rf), 64'd0);
      set_issue(5'd1);
      #1;
      chk("t5_first_dest", 64'(dest_iss), 64'd1);
      tick();
      issue_valid = 1'b0;
      tick();
      chk("t5_no_stale_b", 64'(dest_rf), 64'd0);

      // ---------------- global enable low
      do_reset();
      set_issue(5'd10); tick();
      set_issue(5'd11); tick();
      issue_valid = 1'b0;
      set_cdb(4'd1, 32'h44, 1'b0); tick();
      rdy = 1'b0;
      set_cdb(4'd2, 32'h45, 1'b0);
      set_issue(5'd12);
      #1;
      chk("t6_ready_low", 64'(issue_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t6_hold_commit%0d", i), 64'(dest_rf),  64'd0);
         chk($sformatf("t6_hold_tail%0d", i),   64'(dest_iss), 64'd3);
      end
      rdy = 1'b1;
      #1;
      chk("t6_resume_ready", 64'(issue_ready), 64'd1);
      tick();
      idle_inputs();
      chk("t6_c1_dest",  64'(dest_rf),  64'd1);
      chk("t6_c1_rd",    64'(rd_rf),    64'd10);
      chk("t6_c1_value", 64'(value_rf), 64'h44);
      chk("t6_tail",     64'(dest_iss), 64'd4);
      tick();
      chk("t6_c2_dest",  64'(dest_rf),  64'd2);
      chk("t6_c2_rd",    64'(rd_rf),    64'd11);
      chk("t6_c2_value", 64'(value_rf), 64'h45);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
